// File: rtl/prbs6_pkg.sv
// Shared PRBS6 definitions (x^6 + x^5 + 1) used by the checker and generator models.
package prbs6_pkg;

  localparam int PRBS_W = 6;
  localparam int TAP_A  = 4;
  localparam int TAP_B  = 5;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // h[0] is the newest bit, so q(n-5) sits at TAP_A and q(n-6) at TAP_B.
  function automatic logic next_bit(input logic [PRBS_W-1:0] h);
    return h[TAP_A] ^ h[TAP_B];
  endfunction

endpackage

// File: rtl/prbs6_step.sv
// One PRBS6 step: prediction from history, next history shifting either the input bit or the prediction.
// Purely combinational; no backpressure.
module prbs6_step
  import prbs6_pkg::*;
(
  input  logic [PRBS_W-1:0] h_i,
  input  logic              bit_i,
  input  logic              use_pred_i,
  output logic              pred_o,
  output logic [PRBS_W-1:0] h_next_o
);

  logic shift_bit;

  always_comb begin
    pred_o    = next_bit(h_i);
    shift_bit = use_pred_i ? pred_o : bit_i;
    h_next_o  = {h_i[PRBS_W-2:0], shift_bit};
  end

endmodule

// File: rtl/prbs6_checker.sv
// PRBS6 receive checker: self-syncs, then counts mismatches; all outputs registered (1-cycle latency).
// No backpressure: din_valid gates sampling. Optional bit_count output under PRBS6_CHK_BITCNT_EN.
module prbs6_checker
  import prbs6_pkg::*;
#(
  parameter int LOCK_THRESH = 12,
  parameter int WIN_LEN     = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
`ifdef PRBS6_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  localparam int MR_W = (LOCK_THRESH > 1) ? $clog2(LOCK_THRESH) : 1;
  localparam int WP_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int WE_W = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;

  localparam logic [2:0]      FILL_LAST = 3'(PRBS_W - 1);
  localparam logic [MR_W-1:0] LOCK_LAST = MR_W'(LOCK_THRESH - 1);
  localparam logic [WP_W-1:0] WIN_LAST  = WP_W'(WIN_LEN - 1);
  localparam logic [WE_W-1:0] UNL_LAST  = WE_W'(UNLOCK_ERRS - 1);

  state_e              state_q, state_d;
  logic [PRBS_W-1:0]   h_q, h_d;
  logic [2:0]          fill_cnt_q, fill_cnt_d;
  logic [MR_W-1:0]     match_run_q, match_run_d;
  logic [WP_W-1:0]     win_pos_q, win_pos_d;
  logic [WE_W-1:0]     win_errs_q, win_errs_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic                err_pulse_q, err_pulse_d;
  logic                locked_q, locked_d;

  logic                use_pred;
  logic                pred;
  logic [PRBS_W-1:0]   h_step;
  logic                cnt_mism;
  logic                mism;

  assign use_pred = (state_q == LOCKED);
  assign mism     = (din != pred);

  prbs6_step u_step (
    .h_i        (h_q),
    .bit_i      (din),
    .use_pred_i (use_pred),
    .pred_o     (pred),
    .h_next_o   (h_step)
  );

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_cnt_d  = fill_cnt_q;
    match_run_d = match_run_q;
    win_pos_d   = win_pos_q;
    win_errs_d  = win_errs_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    cnt_mism    = 1'b0;

    unique case (state_q)
      FILL: begin
        if (din_valid) begin
          h_d = h_step;
          if (fill_cnt_q == FILL_LAST) begin
            state_d     = SYNC;
            fill_cnt_d  = '0;
            match_run_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 3'd1;
          end
        end
      end

      SYNC: begin
        if (din_valid) begin
          h_d = h_step;
          // An all-zero history predicts zero forever, so it never counts as a match.
          if (!mism && (h_q != '0)) begin
            if (match_run_q == LOCK_LAST) begin
              state_d     = LOCKED;
              match_run_d = '0;
              win_pos_d   = '0;
              win_errs_d  = '0;
            end else begin
              match_run_d = match_run_q + MR_W'(1);
            end
          end else begin
            match_run_d = '0;
          end
        end
      end

      LOCKED: begin
        if (din_valid) begin
          h_d         = h_step;
          cnt_mism    = mism;
          err_pulse_d = mism;
          win_pos_d   = (win_pos_q == WIN_LAST) ? '0 : win_pos_q + WP_W'(1);
          // Unlock wins over the window wrap on the same bit.
          if (mism && (win_errs_q == UNL_LAST)) begin
            state_d     = FILL;
            h_d         = '0;
            fill_cnt_d  = '0;
            match_run_d = '0;
            win_pos_d   = '0;
            win_errs_d  = '0;
          end else if (win_pos_q == WIN_LAST) begin
            win_errs_d = '0;
          end else if (mism) begin
            win_errs_d = win_errs_q + WE_W'(1);
          end
        end
      end

      default: begin
        state_d = FILL;
        h_d     = '0;
      end
    endcase

    if (clear_cnt) begin
      err_count_d = cnt_mism ? CNT_W'(1) : '0;
    end else if (cnt_mism && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      h_q         <= '0;
      fill_cnt_q  <= '0;
      match_run_q <= '0;
      win_pos_q   <= '0;
      win_errs_q  <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_cnt_q  <= fill_cnt_d;
      match_run_q <= match_run_d;
      win_pos_q   <= win_pos_d;
      win_errs_q  <= win_errs_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

`ifdef PRBS6_CHK_BITCNT_EN
  logic [31:0] bit_count_q, bit_count_d;
  logic        chk_bit;

  assign chk_bit = din_valid && (state_q == LOCKED);

  always_comb begin
    bit_count_d = bit_count_q;
    if (clear_cnt) begin
      bit_count_d = chk_bit ? 32'd1 : 32'd0;
    end else if (chk_bit) begin
      bit_count_d = bit_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs6_checker.sv
// Bench for prbs6_checker: a default instance and a CNT_W=4 instance share one stimulus,
// checked against a queue-based model of the lock/window rules.
module tb_prbs6_checker;

  localparam int LT = 12;
  localparam int WL = 64;
  localparam int UE = 8;

  logic        clk = 1'b0;
  logic        reset, din, din_valid, clear_cnt;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
`ifdef PRBS6_CHK_BITCNT_EN
  logic [31:0] bit_count, bit_count4;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prbs6_checker dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
`ifdef PRBS6_CHK_BITCNT_EN
    , .bit_count(bit_count)
`endif
  );

  prbs6_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
`ifdef PRBS6_CHK_BITCNT_EN
    , .bit_count(bit_count4)
`endif
  );

  // Reference model: raw received bits while acquiring, a replica sequence once locked.
  bit          m_rx[$];
  bit          m_ref[$];
  int          m_run, m_lock_bits, m_win_err, m_errs;
  bit          m_lock, m_pulse;
  int unsigned m_bitcnt;
  bit          gq[$];

  task automatic model_reset();
    m_rx.delete(); m_ref.delete();
    m_run = 0; m_lock_bits = 0; m_win_err = 0; m_errs = 0;
    m_lock = 0; m_pulse = 0; m_bitcnt = 0;
  endtask

  task automatic model_step(input logic v, input logic d, input logic clr);
    int  n;
    bit  pred, nz, counted;
    counted = 0;
    m_pulse = 0;
    if (v && !m_lock) begin
      n = m_rx.size();
      if (n >= 6) begin
        pred = m_rx[n-5] ^ m_rx[n-6];
        nz = 0;
        for (int k = 1; k <= 6; k++) nz |= m_rx[n-k];
        if (d == pred && nz) m_run++;
        else m_run = 0;
      end
      m_rx.push_back(d);
      if (m_run == LT) begin
        m_lock = 1; m_lock_bits = 0; m_win_err = 0; m_run = 0;
        m_ref.delete();
        for (int k = 6; k >= 1; k--) m_ref.push_back(m_rx[m_rx.size()-k]);
      end
    end else if (v) begin
      counted = 1;
      n = m_ref.size();
      pred = m_ref[n-5] ^ m_ref[n-6];
      m_ref.push_back(pred);
      void'(m_ref.pop_front());
      m_bitcnt++;
      m_lock_bits++;
      if (d != pred) begin
        m_pulse = 1; m_errs++; m_win_err++;
      end
      if (m_win_err == UE) begin
        m_lock = 0; m_run = 0; m_rx.delete();
      end else if (m_lock_bits % WL == 0) begin
        m_win_err = 0;
      end
    end
    if (clr) begin
      m_errs   = (counted && m_pulse) ? 1 : 0;
      m_bitcnt = counted ? 1 : 0;
    end
  endtask

  function automatic logic [15:0] sat16();
    return (m_errs > 65535) ? 16'hFFFF : m_errs[15:0];
  endfunction

  function automatic logic [3:0] sat4();
    return (m_errs > 15) ? 4'hF : m_errs[3:0];
  endfunction

  task automatic gen_seed(input logic [5:0] s);
    gq.delete();
    for (int k = 5; k >= 0; k--) gq.push_back(s[k]);
  endtask

  // gq is oldest-first, so gq[0] = q(n-6) and gq[1] = q(n-5).
  task automatic gen_next(output bit b);
    b = gq[0] ^ gq[1];
    void'(gq.pop_front());
    gq.push_back(b);
  endtask

  task automatic tick(input logic v, input logic d, input logic clr);
    din_valid = v; din = d; clear_cnt = clr;
    model_step(v, d, clr);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; din_valid = 1'b0; din = 1'b0; clear_cnt = 1'b0;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0 ||
        locked4 !== 1'b0 || err_pulse4 !== 1'b0 || err_count4 !== 4'd0) begin
      failures++;
      $display("FAIL reset_state locked=%b pulse=%b cnt=%0d cnt4=%0d required all 0",
               locked, err_pulse, err_count, err_count4);
    end
`ifdef PRBS6_CHK_BITCNT_EN
    checks++;
    if (bit_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_bitcnt got=%0d required=0", bit_count);
    end
`endif
  endtask

  task automatic test_clean_lock();
    int rise = -1;
    bit b;
    do_reset();
    gen_seed(6'h01);
    for (int i = 0; i < 500; i++) begin
      gen_next(b);
      tick(1'b1, b, 1'b0);
      if (locked === 1'b1 && rise < 0) rise = i + 1;
      checks++;
      if (locked !== m_lock || locked4 !== m_lock || err_pulse !== m_pulse || err_count !== sat16()) begin
        failures++;
        $display("FAIL clean_model bit=%0d locked=%b/%b pulse=%b/%b cnt=%0d/%0d",
                 i, locked, m_lock, err_pulse, m_pulse, err_count, sat16());
      end
    end
    checks++;
    if (rise != 18) begin
      failures++;
      $display("FAIL clean_lock_latency got=%0d required=18", rise);
    end
    checks++;
    if (err_count !== 16'd0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL clean_500 cnt=%0d locked=%b required cnt=0 locked=1", err_count, locked);
    end
  endtask

  task automatic test_single_error();
    int pulses = 0;
    bit dropped = 0;
    bit b;
    do_reset();
    gen_seed(6'h01);
    for (int i = 0; i < 200; i++) begin
      gen_next(b);
      tick(1'b1, b ^ (i == 100), 1'b0);
      if (err_pulse === 1'b1) pulses++;
      if (i >= 17 && locked !== 1'b1) dropped = 1;
      checks++;
      if (locked !== m_lock || err_pulse !== m_pulse || err_pulse4 !== m_pulse || err_count !== sat16()) begin
        failures++;
        $display("FAIL single_model bit=%0d locked=%b/%b pulse=%b/%b cnt=%0d/%0d",
                 i, locked, m_lock, err_pulse, m_pulse, err_count, sat16());
      end
    end
    checks++;
    if (pulses != 1 || err_count !== 16'd1 || dropped) begin
      failures++;
      $display("FAIL single_error pulses=%0d cnt=%0d dropped=%0d required 1,1,0", pulses, err_count, dropped);
    end
  endtask

  task automatic test_unlock_relock();
    int fall = -1, rise2 = -1;
    bit b, held = 1;
    do_reset();
    gen_seed(6'h01);
    for (int i = 0; i < 160; i++) begin
      gen_next(b);
      tick(1'b1, b ^ (i >= 40 && i <= 54 && (i % 2 == 0)), 1'b0);
      if (fall < 0 && i > 18 && locked === 1'b0) fall = i + 1;
      if (fall > 0 && rise2 < 0 && locked === 1'b1) rise2 = i + 1;
      if (i >= 54 && err_count !== 16'd8) held = 0;
      checks++;
      if (locked !== m_lock || err_pulse !== m_pulse || err_count !== sat16() || err_count4 !== sat4()) begin
        failures++;
        $display("FAIL unlock_model bit=%0d locked=%b/%b pulse=%b/%b cnt=%0d/%0d",
                 i, locked, m_lock, err_pulse, m_pulse, err_count, sat16());
      end
    end
    checks++;
    if (fall != 55) begin
      failures++;
      $display("FAIL unlock_point got=%0d required=55", fall);
    end
    checks++;
    if (rise2 - fall != 18 || !held) begin
      failures++;
      $display("FAIL relock gap=%0d held8=%0d required gap=18 held8=1", rise2 - fall, held);
    end
  endtask

  task automatic test_zero_stream();
    bit seen = 0, seen_t = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (locked !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL zero_stream locked seen=1 required=0");
    end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      tick(1'(i % 2), 1'b0, 1'b0);
      if (locked !== 1'b0) seen_t = 1;
    end
    checks++;
    if (seen_t) begin
      failures++;
      $display("FAIL zero_stream_toggle locked seen=1 required=0");
    end
  endtask

  task automatic test_clear_and_saturate();
    bit b, inj, clr;
    do_reset();
    gen_seed(6'h01);
    for (int i = 0; i < 380; i++) begin
      gen_next(b);
      inj = (i == 25) || (i == 30) || (i == 40) || (i >= 50 && i < 370 && (i - 50) % 16 == 0);
      clr = (i == 40);
      tick(1'b1, b ^ inj, clr);
      if (i == 40) begin
        checks++;
        if (err_count !== 16'd1 || err_count4 !== 4'd1) begin
          failures++;
          $display("FAIL clear_with_error cnt=%0d cnt4=%0d required=1", err_count, err_count4);
        end
      end
      checks++;
      if (locked !== m_lock || err_count !== sat16() || err_count4 !== sat4()) begin
        failures++;
        $display("FAIL clear_model bit=%0d locked=%b/%b cnt=%0d/%0d cnt4=%0d/%0d",
                 i, locked, m_lock, err_count, sat16(), err_count4, sat4());
      end
    end
    checks++;
    if (err_count4 !== 4'd15 || err_count !== 16'd21 || locked !== 1'b1) begin
      failures++;
      $display("FAIL saturate cnt4=%0d cnt=%0d locked=%b required 15,21,1", err_count4, err_count, locked);
    end
  endtask

  task automatic test_reset_mid_sync();
    int rise = -1;
    bit b;
    do_reset();
    gen_seed(6'h01);
    for (int i = 0; i < 16; i++) begin
      gen_next(b);
      tick(1'b1, b, 1'b0);
    end
    reset = 1'b1;
    gen_next(b);
    din_valid = 1'b1; din = b;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid outputs locked=%b pulse=%b cnt=%0d required 0", locked, err_pulse, err_count);
    end
    for (int i = 0; i < 60; i++) begin
      gen_next(b);
      tick(1'b1, b, 1'b0);
      if (rise < 0 && locked === 1'b1) rise = i + 1;
    end
    checks++;
    if (rise != 18) begin
      failures++;
      $display("FAIL reset_mid_relock got=%0d required=18", rise);
    end
`ifdef PRBS6_CHK_BITCNT_EN
    checks++;
    if (bit_count !== 32'd42 || bit_count !== m_bitcnt) begin
      failures++;
      $display("FAIL bitcnt_since_lock got=%0d required=42", bit_count);
    end
`endif
  endtask

  task automatic test_random();
    bit b, v, e, c;
    int rate;
    do_reset();
    gen_seed(6'(($urandom_range(1, 63))));
    for (int i = 0; i < 3000; i++) begin
      rate = (i < 1500) ? 60 : 7;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 199) == 0);
      if (v) begin
        gen_next(b);
        e = ($urandom_range(0, rate - 1) == 0);
        tick(1'b1, b ^ e, c);
      end else begin
        tick(1'b0, 1'($urandom_range(0, 1)), c);
      end
      checks++;
      if (locked !== m_lock || locked4 !== m_lock || err_pulse !== m_pulse ||
          err_count !== sat16() || err_count4 !== sat4()) begin
        failures++;
        $display("FAIL random_model cyc=%0d locked=%b/%b pulse=%b/%b cnt=%0d/%0d cnt4=%0d/%0d",
                 i, locked, m_lock, err_pulse, m_pulse, err_count, sat16(), err_count4, sat4());
      end
`ifdef PRBS6_CHK_BITCNT_EN
      checks++;
      if (bit_count !== m_bitcnt) begin
        failures++;
        $display("FAIL random_bitcnt cyc=%0d got=%0d required=%0d", i, bit_count, m_bitcnt);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; clear_cnt = 1'b0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_unlock_relock();
    test_zero_stream();
    test_clear_and_saturate();
    test_reset_mid_sync();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
